dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: the slave end of the MEM-stage data port (ce/we/sel/addr/wdata -> rdata).
//  Services byte-lane writes and full-word reads from on-chip RAM, inserting read wait states via stall_req_o.
//  Sits between MEM and the pipeline control/stall unit. Byte extraction and sign extension stay in MEM.
// PARAMETERS
//  ADDR_W       12  word-address bits (RAM = 2^ADDR_W words = 16 KB)
//  WAIT_CYCLES  1   extra read wait states beyond the mandatory 1 (0..15)
//  INIT_FILE    ""  optional $readmemh image, ignored if empty
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   reset, synchronous, active-high
//  mem_ce_i     in   1   request valid (`ChipEnable)
//  mem_we_i     in   1   1 = write, 0 = read
//  mem_sel_i    in   4   byte-lane enables, bit n = bits [8n+7:8n]
//  mem_addr_i   in   32  physical byte address; [1:0] ignored
//  mem_data_i   in   32  write data, already lane-positioned
//  flush_i      in   1   pipeline flush (exception); aborts in-flight read
//  mem_data_o   out  32  read data, full word, registered
//  stall_req_o  out  1   hold MEM and earlier stages this cycle
//  ack_o        out  1   transaction completes this cycle
//  err_o        out  1   completing transaction was out of range
// BEHAVIOUR
//  Reset: state IDLE, counter 0, mem_data_o=0, stall_req_o=0, ack_o=0, err_o=0. RAM contents not reset.
//  In-range: mem_addr_i[28:ADDR_W+2]==0. Bits [31:29] are ignored. Index = mem_addr_i[ADDR_W+1:2].
//  FSM states: IDLE, WAIT, RESP.
//  IDLE, ce&we: posted write. Lanes with sel=1 are written at the edge; others are kept.
//   - Same cycle: ack_o=1, stall_req_o=0. err_o=1 and the write is dropped if out of range.
//   - sel=0000: ack with no RAM change.
//  IDLE, ce&!we: latch the index and the range flag, stall_req_o=1 in the same cycle.
//   - Next state WAIT with cnt=WAIT_CYCLES, or RESP if WAIT_CYCLES=0.
//   - The RAM read is synchronous. mem_data_o loads on the edge into RESP; 0 if out of range.
//  WAIT: stall_req_o=1. cnt decrements each cycle; at cnt==1 -> RESP.
//  RESP: stall_req_o=0, ack_o=1, err_o=range flag, mem_data_o valid. Next state IDLE.
//  Read latency: request to ack = 1+WAIT_CYCLES stall cycles; ack in cycle 2+WAIT_CYCLES.
//  mem_data_o holds the last read value until the next read completes. Writes never change it.
//  ce falls, or flush_i=1, while in WAIT (or in the accept cycle): -> IDLE next cycle.
//   - No ack; mem_data_o unchanged; stall_req_o=0 from the following cycle.
//  flush_i in IDLE gates off a write in that cycle: no RAM change, no ack.
//  Request stays presented in the cycle after RESP (pipeline stalled by another source):
//   - treated as a new request. Reads repeat, idempotent. Writes re-commit, same data, harmless.
//  addr/we/sel changing while stall_req_o=1 is a protocol violation. The latched index is used.
//  The bench flags the violation with an assertion.
//  rst has priority over every event, including mid-WAIT: abort, outputs to reset values.
//  stall_req_o = (IDLE & ce & !we & !flush_i) | WAIT. It is forced 0 while rst=1.
//  ack_o and err_o are combinational from state and inputs; err_o implies ack_o.
// STRUCTURE
//  Shared constants in defines.v:
//   - `ChipEnable, `WriteEnable (existing)
//   - new: `DMEM_ADDR_W, `DMEM_WAIT
//   - FSM encodings: `DMEM_IDLE=2'd0, `DMEM_WAIT=2'd1, `DMEM_RESP=2'd2
//  Sub-module dmem_bytelane_ram: 4 byte-wide single-port RAMs.
//   - Ports: clk, we[3:0], addr[ADDR_W-1:0], wdata, rdata. Synchronous read, write-first.
//  The top level holds the FSM, wait counter, range check and output registers.
// TESTING (WAIT_CYCLES=1 unless noted)
//  1. SW 0x12345678 @0x10, sel 1111 -> ack same cycle, no stall.
//     Then LW @0x10 -> stall 2 cycles, RESP mem_data_o=0x12345678, ack=1.
//  2. SB 0x0000AB00 @0x11, sel 0010 -> LW @0x10 returns 0x1234AB78.
//  3. LW @0x10, ce dropped in WAIT -> stall_req_o=0 next cycle, no ack, mem_data_o unchanged.
//     Repeat with flush_i=1: same response.
//  4. LW @0x0001_0000 -> RESP err_o=1, data 0.
//     SW to the same address -> err_o=1, ack=1; RAM image unchanged.
//  5. rst during WAIT -> next cycle all outputs 0, state IDLE. A following LW @0x10 completes normally.
//  6. WAIT_CYCLES=0 and 3: back-to-back LWs @0x0,0x4,0x8 -> stall 1 and 4 cycles per read, one ack each, data correct.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared constants, FSM state encoding and range-check helper for the data-memory responder.
package dmem_responder_pkg;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;

    localparam int unsigned DMEM_ADDR_W      = 12;
    localparam int unsigned DMEM_WAIT_CYCLES = 1;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    // Bits [31:29] are a segment tag and never participate in decoding.
    function automatic logic dmem_in_range(input logic [31:0] addr, input int unsigned addr_w);
        return (addr[28:0] >> (addr_w + 2)) == '0;
    endfunction

endpackage

// File: rtl/dmem_bytelane_ram.sv
// Four byte-wide single-port RAMs sharing one word address; synchronous read, write-first.
module dmem_bytelane_ram #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] r_mem [2**ADDR_W];
        logic [7:0] r_q;

        always_ff @(posedge clk) begin
            if (we[g]) begin
                r_mem[addr] <= wdata[8*g +: 8];
                r_q         <= wdata[8*g +: 8];
            end else begin
                r_q <= r_mem[addr];
            end
        end

        assign rdata[8*g +: 8] = r_q;
    end

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the MEM-stage data port: posted byte-lane writes, full-word reads with
// stall-based wait states, abort on ce drop or flush.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = DMEM_ADDR_W,
    parameter int unsigned WAIT_CYCLES = DMEM_WAIT_CYCLES,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic        flush_i,
    output logic [31:0] mem_data_o,
    output logic        stall_req_o,
    output logic        ack_o,
    output logic        err_o
);

    dmem_state_e       r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_idx;
    logic              r_err;
    logic [31:0]       r_hold;

    logic              w_in_range;
    logic              w_req;
    logic              w_rd_req;
    logic              w_wr_req;
    logic [ADDR_W-1:0] w_idx;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [3:0]        w_ram_we;
    logic [31:0]       w_ram_rdata;
    logic [31:0]       w_rd_word;
    logic              w_unused;

    // Image preload belongs to the memory-implementation flow; INIT_FILE is kept for compatibility.
    assign w_unused = ^{mem_addr_i[31:29], mem_addr_i[1:0], (INIT_FILE != "")};

    assign w_idx      = mem_addr_i[ADDR_W+1:2];
    assign w_in_range = dmem_in_range(mem_addr_i, ADDR_W);
    assign w_req      = (r_state == DMEM_IDLE) && (mem_ce_i == CHIP_ENABLE) && !flush_i;
    assign w_rd_req   = w_req && (mem_we_i != WRITE_ENABLE);
    assign w_wr_req   = w_req && (mem_we_i == WRITE_ENABLE);

    assign w_ram_we   = (w_wr_req && w_in_range && !rst) ? mem_sel_i : '0;
    assign w_ram_addr = (r_state == DMEM_IDLE) ? w_idx : r_idx;
    assign w_rd_word  = r_err ? '0 : w_ram_rdata;

    dmem_bytelane_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (mem_data_i),
        .rdata (w_ram_rdata)
    );

    assign stall_req_o = !rst && (w_rd_req || (r_state == DMEM_WAIT));
    assign ack_o       = !rst && (w_wr_req || (r_state == DMEM_RESP));
    assign err_o       = !rst && ((w_wr_req && !w_in_range) || ((r_state == DMEM_RESP) && r_err));

    // The RAM output register is the read-data flop during RESP; r_hold keeps it afterwards.
    assign mem_data_o  = (r_state == DMEM_RESP) ? w_rd_word : r_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DMEM_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_hold  <= '0;
        end else begin
            case (r_state)
                DMEM_IDLE: begin
                    if (w_rd_req) begin
                        r_idx <= w_idx;
                        r_err <= !w_in_range;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= DMEM_RESP;
                        end else begin
                            r_state <= DMEM_WAIT;
                            r_cnt   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                DMEM_WAIT: begin
                    if ((mem_ce_i != CHIP_ENABLE) || flush_i) begin
                        r_state <= DMEM_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt <= 4'd1) begin
                        r_state <= DMEM_RESP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DMEM_RESP: begin
                    r_hold  <= w_rd_word;
                    r_state <= DMEM_IDLE;
                end
                default: begin
                    r_state <= DMEM_IDLE;
                end
            endcase
        end
    end

endmodule
